// File: rtl/multi_nibble_add_seq_pkg.sv
// rtl/multi_nibble_add_seq_pkg.sv - shared constants, FSM state type and index-width helper for the nibble-serial adder
package multi_nibble_add_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble index width: enough to address every chunk, never narrower than one bit.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/multi_nibble_add_seq_if.sv
// rtl/multi_nibble_add_seq_if.sv - producer/consumer handshake bundle; sub exists only with MULTI_NIBBLE_SUB_EN
interface multi_nibble_add_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef MULTI_NIBBLE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef MULTI_NIBBLE_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

// File: rtl/multi_nibble_add_seq_slice.sv
// rtl/multi_nibble_add_seq_slice.sv - combinational 4-bit ripple-carry adder slice
module nibble_adder_slice
  import multi_nibble_add_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_a,
  input  logic [CHUNK_W-1:0] i_b,
  input  logic               i_ci,
  output logic [CHUNK_W-1:0] o_s,
  output logic               o_co
);

  // Ripple the carry through one full-adder equation per bit.
  always_comb begin
    logic w_c;
    o_s = '0;
    w_c = i_ci;
    for (int k = 0; k < CHUNK_W; k++) begin
      o_s[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/multi_nibble_add_seq.sv
// rtl/multi_nibble_add_seq.sv - WIDTH-bit adder time-sharing one nibble slice, LSB first; MULTI_NIBBLE_SUB_EN adds subtraction
module multi_nibble_add_seq
  import multi_nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_nibble_add_seq_if.slave bus
);

  localparam int CHUNKS = WIDTH / CHUNK_W;
  localparam int IDX_W  = idx_width(CHUNKS);

  generate
    if ((WIDTH < CHUNK_W) || ((WIDTH % CHUNK_W) != 0)) begin : g_bad_width
      $error("multi_nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
`ifdef MULTI_NIBBLE_SUB_EN
  logic               r_sub;
`endif

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;
  logic               w_accept;
  logic               w_last;
  logic [CHUNK_W-1:0] w_a_nib;
  logic [CHUNK_W-1:0] w_b_nib;
  logic [CHUNK_W-1:0] w_b_slice;
  logic [CHUNK_W-1:0] w_s;
  logic               w_co;
  logic [WIDTH-1:0]   w_sum_nxt;
  logic               w_carry_init;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_idx == IDX_W'(CHUNKS - 1));

`ifdef MULTI_NIBBLE_SUB_EN
  // Subtraction is a + ~b + 1, so the carry seeds to 1 and cin is ignored.
  assign w_carry_init = bus.sub ? 1'b1 : bus.cin;
  assign w_b_slice    = r_sub ? ~w_b_nib : w_b_nib;
`else
  assign w_carry_init = bus.cin;
  assign w_b_slice    = w_b_nib;
`endif

  // Select the operand nibbles addressed by the current pass.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_nib = r_a[k*CHUNK_W +: CHUNK_W];
        w_b_nib = r_b[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  nibble_adder_slice u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_slice),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // Merge the fresh slice result into its nibble; other nibbles hold.
  always_comb begin
    w_sum_nxt = r_sum;
    for (int k = 0; k < CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sum_nxt[k*CHUNK_W +: CHUNK_W] = w_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake outputs; in_ready is forced low while rst is high.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = !rst;
        if (bus.in_valid && !rst) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then one nibble per cycle during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef MULTI_NIBBLE_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= w_carry_init;
            r_idx   <= '0;
`ifdef MULTI_NIBBLE_SUB_EN
            r_sub   <= bus.sub;
`endif
          end
        end
        RUN: begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_co;
          if (w_last) begin
            r_cout <= w_co;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_multi_nibble_add_seq.sv
// tb/tb_multi_nibble_add_seq.sv - directed self-checking bench for multi_nibble_add_seq (WIDTH=16)
module tb_multi_nibble_add_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;

  multi_nibble_add_seq_if #(.WIDTH(16)) bus ();

  multi_nibble_add_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input string tag,
                       input logic [15:0] es, input logic ec, output int acc_cyc);
    int lat;
    chk({tag, " in_ready before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
`ifdef MULTI_NIBBLE_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd4);
    chk({tag, " sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({tag, " cout"}, {31'd0, bus.cout}, {31'd0, ec});
    @(posedge clk); #1;
    chk({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int c1, c2, dummy;
    logic seen;
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MULTI_NIBBLE_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset sum", {16'd0, bus.sum}, 32'd0);
    chk("reset cout", {31'd0, bus.cout}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, $sformatf("vec%0d", i),
            vecs[i].exp_sum, vecs[i].exp_cout, dummy);
    end

    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, "b2b first", 16'h5556, 1'b0, c1);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, "b2b second", 16'h0000, 1'b1, c2);
    chk("issue interval", c2 - c1, 32'd6);

    bus.a = 16'h00FF;
    bus.b = 16'h0001;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp out_valid rise", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.a = 16'h1111 * (i + 2);
      bus.b = 16'h2222 + 16'(i);
      bus.cin = 1'(i);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d sum", i), {16'd0, bus.sum}, 32'h0100);
      chk($sformatf("bp%0d cout", i), {31'd0, bus.cout}, 32'd0);
      chk($sformatf("bp%0d in_ready", i), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp release busy", {31'd0, bus.busy}, 32'd0);
    chk("bp sum held", {16'd0, bus.sum}, 32'h0100);

    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid rst sum", {16'd0, bus.sum}, 32'd0);
    chk("mid rst cout", {31'd0, bus.cout}, 32'd0);
    chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
    chk("mid rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    chk("aborted op no out_valid", {31'd0, seen}, 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, "post rst op", 16'h0002, 1'b0, dummy);

`ifdef MULTI_NIBBLE_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub 5-7", 16'hFFFE, 1'b0, dummy);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub 7-5", 16'h0002, 1'b1, dummy);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_nibble_add_seq.md
Name: multi_nibble_add_seq

Overview:
Multi-cycle controller that performs a WIDTH-bit add by time-sharing a single 4-bit ripple-carry adder slice, one nibble per cycle, LSB nibble first. A registered carry chains the nibbles together.
It sits between a producer and a consumer with valid/ready handshakes on both sides. It is used wherever area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
CHUNKS, WIDTH/4 (localparam), number of nibble passes per operation

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for the LSB nibble
out_valid  output  1  sum/cout are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result
cout  output  1  carry-out of the MSB nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, operand registers=0.
- in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- FSM states:
  - IDLE: on in_valid&&in_ready, latch a, b; set carry<=cin, idx<=0; go to RUN.
  - RUN: the slice adds a_r[idx*4+:4] + b_r[idx*4+:4] + carry.
    - Each edge: sum[idx*4+:4]<=slice sum, carry<=slice cout, idx<=idx+1.
    - When idx==CHUNKS-1: also set cout<=slice cout and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE; sum/cout keep their values until the next acceptance.
- Latency: out_valid rises exactly CHUNKS rising edges after the acceptance edge (4 for WIDTH=16).
- Minimum issue interval: CHUNKS+2 cycles. There is no overlap: in_ready=0 in RUN and DONE.
- Operands are latched at acceptance. Changes on a/b/cin/in_valid outside IDLE are ignored.
- Backpressure: in DONE with out_ready=0, out_valid stays 1 and sum/cout stay constant indefinitely.
- Carry wraps across nibble boundaries only through the carry register. No overflow flag; cout is the unsigned carry-out.
- Sum nibbles not yet computed during RUN keep their previous values. Sum is only meaningful while out_valid=1.
- Reset mid-operation aborts immediately: no out_valid is produced. in_ready goes to 1 in the first cycle after rst deasserts.
- idx width is $clog2(CHUNKS), minimum 1 bit. idx never exceeds CHUNKS-1.

Optional Feature:
MULTI_NIBBLE_SUB_EN
- Defined: adds input port sub (1 bit), latched at acceptance.
  - When sub=1, the slice b input is ~b_r nibble and carry is initialised to 1 (the cin input is ignored).
  - Result is a - b in two's complement. cout=1 means no borrow.
- Not defined: no sub port; add only.

Decomposition:
- Package multi_nibble_add_pkg contains:
  - CHUNK_W=4 constant
  - state_t enum {IDLE, RUN, DONE}
- Sub-module nibble_adder_slice: purely combinational 4-bit add (a[3:0], b[3:0], ci) -> (s[3:0], co).
  - Instantiated once.
  - Internally a ripple chain of 1-bit full-add equations.

Test Plan:
- WIDTH=16, a=0x00FF, b=0x0001, cin=0, out_ready=1 -> out_valid exactly 4 edges after accept; sum=0x0100, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 nibble passes).
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. A second op a=0x8000, b=0x8000 issued as soon as in_ready returns -> sum=0x0000, cout=1; issue interval 6 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b.
  - Expected: sum/cout/out_valid stable, in_ready=0, no new op accepted.
  - Release out_ready: one handshake, then IDLE.
- Assert rst for 1 cycle during RUN at idx=2 -> out_valid never rises; all outputs 0; in_ready=1 in the cycle after release; next op a=0x0001, b=0x0001 -> sum=0x0002.
- With MULTI_NIBBLE_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
